// File: rtl/sm_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers (MULTU/DIVU/MTHI/MTLO).
// Define MULDIV_SIGNED_EN to also accept signed MULT (oper 4) and DIV (oper 5).
module sm_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       oper,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [CW-1:0]        cnt_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic [WIDTH:0]       rem_r;
    logic                 div_r;

    logic                 op_iter_s;
    logic                 op_div_s;
    logic                 op_mthi_s;
    logic                 op_mtlo_s;
    logic [WIDTH-1:0]     mag_a_s;
    logic [WIDTH-1:0]     mag_b_s;

    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   prod_step_s;
    logic [WIDTH:0]       div_trial_s;
    logic                 div_ge_s;
    logic [WIDTH:0]       rem_step_s;
    logic [WIDTH-1:0]     quo_step_s;
    logic [WIDTH-1:0]     res_hi_s;
    logic [WIDTH-1:0]     res_lo_s;

`ifdef MULDIV_SIGNED_EN
    logic                 op_sgn_s;
    logic                 sgn_r;
    logic                 neg_q_r;
    logic                 neg_r_r;
    logic [2*WIDTH-1:0]   prod_neg_s;
`endif

    assign busy = (state_r == RUN);
    assign done = (state_r == DONE);
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Decode an accepted request; start only matters outside RUN.
    always_comb begin
        op_iter_s = 1'b0;
        op_div_s  = 1'b0;
        op_mthi_s = 1'b0;
        op_mtlo_s = 1'b0;
`ifdef MULDIV_SIGNED_EN
        op_sgn_s  = 1'b0;
`endif
        if (start && (state_r != RUN)) begin
            case (oper)
                3'd0: op_iter_s = 1'b1;
                3'd1: begin
                    op_iter_s = 1'b1;
                    op_div_s  = 1'b1;
                end
                3'd2: op_mthi_s = 1'b1;
                3'd3: op_mtlo_s = 1'b1;
`ifdef MULDIV_SIGNED_EN
                3'd4: begin
                    op_iter_s = 1'b1;
                    op_sgn_s  = 1'b1;
                end
                3'd5: begin
                    op_iter_s = 1'b1;
                    op_div_s  = 1'b1;
                    op_sgn_s  = 1'b1;
                end
`endif
                default: op_iter_s = 1'b0;
            endcase
        end else begin
            op_iter_s = 1'b0;
        end
    end

    // Operand magnitudes fed to the unsigned datapath.
    always_comb begin
        mag_a_s = srcA;
        mag_b_s = srcB;
`ifdef MULDIV_SIGNED_EN
        if (op_sgn_s) begin
            mag_a_s = srcA[WIDTH-1] ? -srcA : srcA;
            mag_b_s = srcB[WIDTH-1] ? -srcB : srcB;
        end else begin
            mag_a_s = srcA;
            mag_b_s = srcB;
        end
`endif
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (op_iter_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // One shift-add step and one restoring-divide step per clock.
    always_comb begin
        mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
                    + (prod_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        prod_step_s = {mul_sum_s, prod_r[WIDTH-1:1]};
        div_trial_s = {rem_r[WIDTH-1:0], prod_r[WIDTH-1]};
        // rem_r[WIDTH] set would mean the shifted remainder already exceeds any divisor
        div_ge_s    = rem_r[WIDTH] || (div_trial_s >= {1'b0, b_r});
        if (div_ge_s) begin
            rem_step_s = div_trial_s - {1'b0, b_r};
        end else begin
            rem_step_s = div_trial_s;
        end
        quo_step_s  = {prod_r[WIDTH-2:0], div_ge_s};
    end

`ifdef MULDIV_SIGNED_EN
    assign prod_neg_s = -prod_step_s;
`endif

    // Final result written on the last RUN edge, including any sign fix-up.
    always_comb begin
        if (div_r) begin
            res_hi_s = rem_step_s[WIDTH-1:0];
            res_lo_s = quo_step_s;
        end else begin
            res_hi_s = prod_step_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_step_s[WIDTH-1:0];
        end
`ifdef MULDIV_SIGNED_EN
        if (sgn_r && !div_r && neg_q_r) begin
            res_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_neg_s[WIDTH-1:0];
        end else if (sgn_r && div_r && (b_r != {WIDTH{1'b0}})) begin
            if (neg_q_r) begin
                res_lo_s = -quo_step_s;
            end else begin
                res_lo_s = quo_step_s;
            end
            if (neg_r_r) begin
                res_hi_s = -rem_step_s[WIDTH-1:0];
            end else begin
                res_hi_s = rem_step_s[WIDTH-1:0];
            end
        end else begin
            res_hi_s = res_hi_s;
        end
`endif
    end

    // State, datapath and HI/LO registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            prod_r  <= {(2*WIDTH){1'b0}};
            rem_r   <= {(WIDTH+1){1'b0}};
            div_r   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sgn_r   <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
`endif
        end else begin
            state_r <= state_next_s;
            if (op_mthi_s) begin
                hi_r <= srcA;
            end
            if (op_mtlo_s) begin
                lo_r <= srcA;
            end
            if (op_iter_s) begin
                a_r    <= mag_a_s;
                b_r    <= mag_b_s;
                prod_r <= {{WIDTH{1'b0}}, (op_div_s ? mag_a_s : mag_b_s)};
                rem_r  <= {(WIDTH+1){1'b0}};
                cnt_r  <= CNT_INIT;
                div_r  <= op_div_s;
`ifdef MULDIV_SIGNED_EN
                sgn_r   <= op_sgn_s;
                neg_q_r <= srcA[WIDTH-1] ^ srcB[WIDTH-1];
                neg_r_r <= srcA[WIDTH-1];
`endif
            end else if (state_r == RUN) begin
                if (div_r) begin
                    prod_r <= {prod_r[2*WIDTH-1:WIDTH], quo_step_s};
                    rem_r  <= rem_step_s;
                end else begin
                    prod_r <= prod_step_s;
                end
                if (cnt_r == {CW{1'b0}}) begin
                    hi_r <= res_hi_s;
                    lo_r <= res_lo_s;
                end else begin
                    cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: tb/tb_sm_muldiv.sv
// Scoreboard bench for sm_muldiv (WIDTH=32): arithmetic reference model, decoupled done monitor.
module tb_sm_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    oper;
    logic [W-1:0]  srcA;
    logic [W-1:0]  srcB;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    sm_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .oper(oper),
        .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           acc_edge;
    } exp_t;

    exp_t         sb_q[$];
    int           n_vec = 0;
    int           n_miss = 0;
    int           ecnt = 0;
    int           busy_len = 0;
    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (busy) begin
                busy_len++;
            end else if (done) begin
                if (sb_q.size() == 0) begin
                    check("spurious_done", 64'(done), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("hi", 64'(hi), 64'(e.hi));
                    check("lo", 64'(lo), 64'(e.lo));
                    check("done_latency", 64'(ecnt), 64'(e.acc_edge + W));
                    check("busy_len", 64'(busy_len), 64'(W));
                end
                busy_len = 0;
            end else begin
                busy_len = 0;
            end
        end else begin
            busy_len = 0;
        end
    end

    task automatic push(input logic [W-1:0] h, input logic [W-1:0] l);
        sb_q.push_back('{hi: h, lo: l, acc_edge: ecnt + 1});
        mhi = h;
        mlo = l;
    endtask

    // Issue one request; must be called just after a falling edge.
    task automatic go(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic         iter;
        logic [63:0]  p;
        longint       sa, sb, qq, rr;
        iter  = 1'b0;
        start = 1'b1;
        oper  = op;
        srcA  = a;
        srcB  = b;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        case (op)
            3'd0: begin
                p = {32'd0, a} * {32'd0, b};
                push(p[63:32], p[31:0]);
                iter = 1'b1;
            end
            3'd1: begin
                if (b == 0) push(a, 32'hFFFF_FFFF);
                else        push(a % b, a / b);
                iter = 1'b1;
            end
            3'd2: mhi = a;
            3'd3: mlo = a;
`ifdef MULDIV_SIGNED_EN
            3'd4: begin
                qq = sa * sb;
                push(qq[63:32], qq[31:0]);
                iter = 1'b1;
            end
            3'd5: begin
                if (b == 0) begin
                    push(a[31] ? -a : a, 32'hFFFF_FFFF);
                end else begin
                    qq = sa / sb;
                    rr = sa % sb;
                    push(rr[31:0], qq[31:0]);
                end
                iter = 1'b1;
            end
`endif
            default: iter = 1'b0;
        endcase
        @(negedge clk);
        start = 1'b0;
        oper  = 3'($urandom_range(0, 7));
        srcA  = $urandom;
        srcB  = $urandom;
        if (iter) begin
            check("busy_rise", 64'(busy), 64'd1);
        end else begin
            check("noiter_busy", 64'(busy), 64'd0);
            check("noiter_done", 64'(done), 64'd0);
            check("noiter_hi", 64'(hi), 64'(mhi));
            check("noiter_lo", 64'(lo), 64'(mlo));
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && (sb_q.size() != 0 || busy || done); i++) @(negedge clk);
        check("idle_timeout", 64'(sb_q.size() != 0 || busy), 64'd0);
    endtask

    initial begin
        int seen;
        logic [W-1:0] ra, rb;
        rst_n = 1'b0;
        start = 1'b0;
        oper  = 3'd0;
        srcA  = '0;
        srcB  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        go(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        check("t1_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        check("t1_lo", 64'(lo), 64'h1);

        go(3'd1, 32'd100, 32'd7);
        wait_idle();
        check("t2_lo", 64'(lo), 64'hE);
        check("t2_hi", 64'(hi), 64'h2);
        go(3'd1, 32'd5, 32'd0);
        wait_idle();
        check("t2z_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
        check("t2z_hi", 64'(hi), 64'h5);

        go(3'd2, 32'h0000_1234, 32'h0);
        check("t3_mthi", 64'(hi), 64'h1234);
        go(3'd0, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        start = 1'b1;
        oper  = 3'd3;
        srcA  = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("t3_hi", 64'(hi), 64'h0);
        check("t3_lo", 64'(lo), 64'hC);

        go(3'd0, $urandom, $urandom);
        for (int i = 0; i < 60 && !done; i++) @(negedge clk);
        check("b2b_done_seen", 64'(done), 64'd1);
        go(3'd1, $urandom, 32'($urandom_range(1, 1000)));
        wait_idle();

        go(3'd0, $urandom, $urandom);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        mhi = '0;
        mlo = '0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        seen = 0;
        for (int i = 0; i < W + 5; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("midrst_nodone", 64'(seen), 64'd0);

`ifdef MULDIV_SIGNED_EN
        go(3'd4, -32'sd3, 32'd5);
        wait_idle();
        check("t6_mult_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        check("t6_mult_lo", 64'(lo), 64'h0000_0000_FFFF_FFF1);
        go(3'd5, -32'sd7, 32'd2);
        wait_idle();
        check("t6_div_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        check("t6_div_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
`else
        go(3'd2, 32'hCAFE_0001, 32'h0);
        go(3'd4, 32'd9, 32'd9);
        go(3'd5, 32'd9, 32'd3);
        check("t6_ign_hi", 64'(hi), 64'h0000_0000_CAFE_0001);
`endif
        go(3'd6, 32'd1, 32'd1);
        go(3'd7, 32'd1, 32'd1);

        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 255));
                2:       rb = {1'b1, 31'($urandom)};
                default: rb = $urandom;
            endcase
            go(3'($urandom_range(0, 7)), ra, rb);
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
